// File: rtl/sonar_ping_sequencer.sv
// Sonar ping sequencer: drives the ultrasonic trigger pulse, runs the 13-bit
// time-of-flight timer sampled by the capture stage, pulses capture_clear at
// the start of each ping, and enforces a hold-off gap before the next ping.
module sonar_ping_sequencer #(
  parameter int unsigned TRIG_CYCLES    = 500,   // trig pulse width in clocks
  parameter int unsigned TICK_DIV       = 50,    // clocks per timer increment (>= 1)
  parameter int unsigned TIMEOUT        = 8191,  // last timer value of the listen window (<= 8191)
  parameter int unsigned HOLDOFF_CYCLES = 1000   // idle gap after the listen window
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        auto,
  output logic        trig,
  output logic [12:0] timer,
  output logic        capture_clear,
  output logic        busy,
  output logic        done
);

  // One phase counter is shared by TRIG and HOLDOFF, so size it for the longer one.
  localparam int unsigned PH_MAX = (TRIG_CYCLES > HOLDOFF_CYCLES) ? TRIG_CYCLES : HOLDOFF_CYCLES;
  localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;
  localparam int unsigned PRE_W  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [PH_W-1:0]  TRIG_LAST    = PH_W'(TRIG_CYCLES - 1);
  localparam logic [PH_W-1:0]  HOLDOFF_LAST = PH_W'(HOLDOFF_CYCLES - 1);
  localparam logic [PRE_W-1:0] PRE_LAST     = PRE_W'(TICK_DIV - 1);
  localparam logic [12:0]      TIMEOUT_V    = 13'(TIMEOUT);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_TRIG,
    ST_LISTEN,
    ST_HOLDOFF
  } state_t;

  state_t           state_q;
  logic [PH_W-1:0]  phase_q;
  logic [PRE_W-1:0] presc_q;
  logic [12:0]      timer_q;
  logic             trig_q;
  logic             clear_q;
  logic             busy_q;
  logic             done_q;

  // Ping state machine; every output is registered and changes together with the state.
  // NOTE: sequential state uses non-blocking assignments so every register samples
  // the pre-edge values of the others, regardless of statement order.
  always_ff @(posedge clk) begin
    // NOTE: reset is synchronous; it is just the highest-priority branch of the clocked block.
    if (reset) begin
      state_q <= ST_IDLE;
      phase_q <= '0;
      presc_q <= '0;
      timer_q <= '0;
      trig_q  <= 1'b0;
      clear_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      // Single-cycle pulses fall back to 0 unless a branch below raises them.
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (start || auto) begin
            state_q <= ST_TRIG;
            phase_q <= '0;
            timer_q <= '0;
            trig_q  <= 1'b1;
            clear_q <= 1'b1;
            busy_q  <= 1'b1;
          end
        end
        ST_TRIG: begin
          if (phase_q == TRIG_LAST) begin
            state_q <= ST_LISTEN;
            trig_q  <= 1'b0;
            presc_q <= '0;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        ST_LISTEN: begin
          if (presc_q == PRE_LAST) begin
            presc_q <= '0;
            if (timer_q == TIMEOUT_V) begin
              // Window closes on the wrap at TIMEOUT; timer stays put.
              state_q <= ST_HOLDOFF;
              done_q  <= 1'b1;
              phase_q <= '0;
            end else begin
              timer_q <= timer_q + 1'b1;
            end
          end else begin
            presc_q <= presc_q + 1'b1;
          end
        end
        ST_HOLDOFF: begin
          if (phase_q == HOLDOFF_LAST) begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
            phase_q <= '0;
          end else begin
            phase_q <= phase_q + 1'b1;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          busy_q  <= 1'b0;
          trig_q  <= 1'b0;
        end
      endcase
    end
  end

  assign trig          = trig_q;
  assign timer         = timer_q;
  assign capture_clear = clear_q;
  assign busy          = busy_q;
  assign done          = done_q;

endmodule

// File: tb/tb_sonar_ping_sequencer.sv
// Self-checking bench for sonar_ping_sequencer: table-driven single ping,
// hand-written corner sequences, randomized traffic against a cycle-index
// reference model, and a long-window run with wide timing parameters.
module tb_sonar_ping_sequencer;

  // Small configuration used by the table, corner sequences and random traffic.
  localparam int T    = 3;
  localparam int D    = 2;
  localparam int TO   = 5;
  localparam int H    = 4;
  localparam int L    = (TO + 1) * D;  // listen window length
  localparam int PING = T + L + H;     // busy cycles per ping

  // Wide configuration: real trigger and hold-off, full 13-bit timer range.
  localparam int BT  = 500;
  localparam int BD  = 3;
  localparam int BTO = 8191;
  localparam int BH  = 1000;

  logic        clk = 1'b0;
  logic        reset = 1'b1, start = 1'b0, auto = 1'b0;
  logic        trig, capture_clear, busy, done;
  logic [12:0] timer;

  logic        big_reset = 1'b1, big_start = 1'b0, big_auto = 1'b0;
  logic        big_trig, big_clear, big_busy, big_done;
  logic [12:0] big_timer;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  sonar_ping_sequencer #(
    .TRIG_CYCLES(T), .TICK_DIV(D), .TIMEOUT(TO), .HOLDOFF_CYCLES(H)
  ) u_dut (
    .clk(clk), .reset(reset), .start(start), .auto(auto),
    .trig(trig), .timer(timer), .capture_clear(capture_clear),
    .busy(busy), .done(done)
  );

  sonar_ping_sequencer #(
    .TRIG_CYCLES(BT), .TICK_DIV(BD), .TIMEOUT(BTO), .HOLDOFF_CYCLES(BH)
  ) u_big (
    .clk(clk), .reset(big_reset), .start(big_start), .auto(big_auto),
    .trig(big_trig), .timer(big_timer), .capture_clear(big_clear),
    .busy(big_busy), .done(big_done)
  );

  task automatic check(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: position inside the ping (0 = idle, 1..PING = ping cycle).
  int m_k = 0;
  int m_timer = 0;

  task automatic model_update(input logic r, input logic s, input logic a);
    if (r) begin
      m_k = 0;
      m_timer = 0;
    end else if (m_k == 0) begin
      if (s || a) m_k = 1;
    end else if (m_k == PING) begin
      m_k = 0;
    end else begin
      m_k++;
    end
    if (m_k >= 1 && m_k <= T)          m_timer = 0;
    else if (m_k > T && m_k <= T + L)  m_timer = (m_k - T - 1) / D;
    else if (m_k > T + L)              m_timer = TO;
  endtask

  task automatic check_model(input string tag);
    check({tag, ".trig"},  int'(trig),          int'(m_k >= 1 && m_k <= T));
    check({tag, ".clear"}, int'(capture_clear), int'(m_k == 1));
    check({tag, ".busy"},  int'(busy),          int'(m_k != 0));
    check({tag, ".done"},  int'(done),          int'(m_k == T + L + 1));
    check({tag, ".timer"}, int'(timer),         m_timer);
  endtask

  // Drive inputs for one cycle, advance the model, then sample after the edge.
  task automatic cycle(input logic r, input logic s, input logic a);
    reset = r; start = s; auto = a;
    model_update(r, s, a);
    @(posedge clk);
    #1;
  endtask

  task automatic check_outs(input string tag, input int e_trig, input int e_clr,
                            input int e_busy, input int e_done, input int e_timer);
    check({tag, ".trig"},  int'(trig),          e_trig);
    check({tag, ".clear"}, int'(capture_clear), e_clr);
    check({tag, ".busy"},  int'(busy),          e_busy);
    check({tag, ".done"},  int'(done),          e_done);
    check({tag, ".timer"}, int'(timer),         e_timer);
  endtask

  // Vector i drives the inputs during cycle i; expectations are for cycle i+1.
  typedef struct {
    logic rst, st, au;
    int   trig, clr, busy, done, timer;
  } vec_t;

  vec_t vecs[20];

  task automatic run_table(input string tag, input bit repulse);
    logic s;
    for (int i = 0; i < 20; i++) begin
      s = vecs[i].st;
      if (repulse && (i == 2 || i == 8 || i == 17)) s = 1'b1;
      cycle(vecs[i].rst, s, vecs[i].au);
      check_outs($sformatf("%s.c%0d", tag, i + 1), vecs[i].trig, vecs[i].clr,
                 vecs[i].busy, vecs[i].done, vecs[i].timer);
    end
  endtask

  initial begin
    int n_clr, n_done, trig_cnt, max_t, prev_t, listen_at, done_at, wraps;
    bit finished;

    //            rst   st    au    trig clr busy done timer
    vecs[0]  = '{1'b0, 1'b1, 1'b0, 1, 1, 1, 0, 0};
    vecs[1]  = '{1'b0, 1'b0, 1'b0, 1, 0, 1, 0, 0};
    vecs[2]  = '{1'b0, 1'b0, 1'b0, 1, 0, 1, 0, 0};
    vecs[3]  = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 0};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 0};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 1};
    vecs[6]  = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 1};
    vecs[7]  = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 2};
    vecs[8]  = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 2};
    vecs[9]  = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 3};
    vecs[10] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 3};
    vecs[11] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 4};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 4};
    vecs[13] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 5};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 5};
    vecs[15] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 1, 5};
    vecs[16] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 5};
    vecs[17] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 5};
    vecs[18] = '{1'b0, 1'b0, 1'b0, 0, 0, 1, 0, 5};
    vecs[19] = '{1'b0, 1'b0, 1'b0, 0, 0, 0, 0, 5};

    // Reset held with start high, then released with start low: nothing happens.
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 1'b1, 1'b0);
      check_outs($sformatf("rst_hold%0d", i), 0, 0, 0, 0, 0);
    end
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      check_outs($sformatf("rst_rel%0d", i), 0, 0, 0, 0, 0);
    end

    // Single start pulse, then the same ping with start re-pulsed mid-ping.
    run_table("single", 1'b0);
    run_table("repulse", 1'b1);
    cycle(1'b0, 1'b0, 1'b0);
    check_outs("repulse.after", 0, 0, 0, 0, 5);

    // Reset in LISTEN while timer is 3 aborts with no done pulse.
    cycle(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 9; i++) cycle(1'b0, 1'b0, 1'b0);
    check_outs("abort.pre", 0, 0, 1, 0, 3);
    cycle(1'b1, 1'b0, 1'b0);
    check_outs("abort.post", 0, 0, 0, 0, 0);
    n_done = 0;
    for (int i = 0; i < 20; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      n_done += int'(done);
      check_model("abort.idle");
    end
    check("abort.no_done", n_done, 0);
    run_table("after_abort", 1'b0);

    // Auto-repeat: pings start at cycles 1, 21, 41 within a 60-cycle window.
    n_clr = 0; n_done = 0;
    for (int i = 0; i < 60; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      n_clr  += int'(capture_clear);
      n_done += int'(done);
      check_model($sformatf("auto%0d", i + 1));
      if (i == 20 || i == 40) check($sformatf("auto.clear_at%0d", i + 1), int'(capture_clear), 1);
    end
    check("auto.clears", n_clr, 3);
    check("auto.dones", n_done, 3);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b0, 1'b0, 1'b1);
      check_model("auto.tail");
    end
    // Drop auto mid-ping: that ping finishes, then the block stays idle.
    n_clr = 0; n_done = 0;
    for (int i = 0; i < 40; i++) begin
      cycle(1'b0, 1'b0, 1'b0);
      n_clr  += int'(capture_clear);
      n_done += int'(done);
      check_model("auto_drop");
    end
    check("auto_drop.clears", n_clr, 0);
    check("auto_drop.dones", n_done, 1);
    check("auto_drop.idle", int'(busy), 0);

    // Randomized traffic against the reference model.
    for (int i = 0; i < 3000; i++) begin
      logic r, s, a;
      r = ($urandom_range(0, 149) == 0);
      s = ($urandom_range(0, 5) == 0);
      a = auto;
      if ($urandom_range(0, 63) == 0) a = ~auto;
      cycle(r, s, a);
      check_model("rand");
    end
    cycle(1'b1, 1'b0, 1'b0);
    check_outs("rand.reset", 0, 0, 0, 0, 0);

    // Wide configuration: 500-cycle trigger, timer runs to 8191 without wrapping.
    big_reset = 1'b1;
    @(posedge clk); #1;
    big_reset = 1'b0;
    @(posedge clk); #1;
    check("big.idle_busy", int'(big_busy), 0);
    big_start = 1'b1;
    @(posedge clk); #1;
    big_start = 1'b0;
    check("big.clear_first", int'(big_clear), 1);
    trig_cnt = 0; max_t = 0; prev_t = 0; listen_at = -1; done_at = -1; wraps = 0;
    finished = 1'b0;
    for (int n = 1; n <= 30000; n++) begin
      if (!big_busy) begin
        finished = 1'b1;
        break;
      end
      trig_cnt += int'(big_trig);
      if (!big_trig && listen_at < 0) listen_at = n;
      if (big_done) begin
        done_at = n;
        check("big.timer_at_done", int'(big_timer), BTO);
      end
      if (int'(big_timer) < prev_t) wraps++;
      if (int'(big_timer) > max_t) max_t = int'(big_timer);
      prev_t = int'(big_timer);
      @(posedge clk); #1;
    end
    check("big.finished", int'(finished), 1);
    check("big.trig_width", trig_cnt, BT);
    check("big.timer_max", max_t, BTO);
    check("big.no_wrap", wraps, 0);
    check("big.listen_start", listen_at, BT + 1);
    check("big.done_delay", done_at - listen_at, (BTO + 1) * BD);
    check("big.final_timer", int'(big_timer), BTO);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
